// File: rtl/effect_chain_sequencer.sv
// Effect chain sequencer: walks one captured sample through up to three effect
// stages, with config-change stage reset, per-stage timeout and sticky error flags.
module effect_chain_sequencer #(
    parameter int unsigned TIMEOUT      = 1023,
    parameter int unsigned RESET_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic signed [11:0] sample_in,
    input  logic [4:0]         delay_amount,
    input  logic [2:0]         effect_enable,
    input  logic               clear_flags,
    input  logic [2:0]         stage_done,
    input  logic [35:0]        stage_out,
    output logic signed [11:0] stage_sample,
    output logic [2:0]         stage_start,
    output logic               stage_reset,
    output logic [4:0]         stage_delay_amount,
    output logic [2:0]         stage_enable,
    output logic signed [11:0] sample_out,
    output logic               sample_valid,
    output logic               busy,
    output logic               overrun_err,
    output logic               timeout_err
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CFG_RESET, LAUNCH, ARM, WAIT, OUTPUT} state_e;

    state_e             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic signed [11:0] work_q, work_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [4:0]         dly_q, dly_d;
    logic [2:0]         en_q, en_d;
    logic signed [11:0] out_q, out_d;
    logic [2:0]         start_q, start_d;
    logic               rst_q, rst_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic               terr_q, terr_d;
    logic               ovr_set, tmo_set, adv, en_sel, done_sel;
    logic [11:0]        out_sel;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        tmo_d   = tmo_q;
        rcnt_d  = rcnt_q;
        dly_d   = dly_q;
        en_d    = en_q;
        out_d   = out_q;
        ovr_set = 1'b0;
        tmo_set = 1'b0;
        adv     = 1'b0;
        case (k_q)
            2'd0:    out_sel = stage_out[11:0];
            2'd1:    out_sel = stage_out[23:12];
            default: out_sel = stage_out[35:24];
        endcase
        en_sel   = |((3'b001 << k_q) & en_q);
        done_sel = |((3'b001 << k_q) & stage_done);

        case (state_q)
            IDLE: begin
                // A config change always wins; a coincident sample is lost.
                if ({delay_amount, effect_enable} != {dly_q, en_q}) begin
                    dly_d   = delay_amount;
                    en_d    = effect_enable;
                    rcnt_d  = '0;
                    state_d = CFG_RESET;
                    ovr_set = ready;
                end else if (ready) begin
                    work_d  = sample_in;
                    k_d     = 2'd0;
                    state_d = LAUNCH;
                end
            end
            CFG_RESET: begin
                if (rcnt_q == RW'(RESET_CYCLES - 1)) state_d = IDLE;
                else rcnt_d = rcnt_q + 1'b1;
            end
            LAUNCH: begin
                if (en_sel) state_d = ARM;
                else adv = 1'b1;
            end
            ARM: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_sel) begin
                    work_d = out_sel;
                    adv    = 1'b1;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    adv     = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            OUTPUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (k_q == 2'd2) begin
                state_d = OUTPUT;
            end else begin
                k_d     = k_q + 2'd1;
                state_d = LAUNCH;
            end
        end
        if (ready && state_q != IDLE) ovr_set = 1'b1;

        // Outputs are decoded from the next state so they are registered with it.
        start_d = (state_d == LAUNCH) ? ((3'b001 << k_d) & en_d) : '0;
        rst_d   = (state_d == CFG_RESET);
        valid_d = (state_d == OUTPUT);
        busy_d  = (state_d != IDLE);
        if (state_d == OUTPUT) out_d = work_d;
        ovr_d   = ovr_set | (ovr_q & ~clear_flags);
        terr_d  = tmo_set | (terr_q & ~clear_flags);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
            tmo_q   <= '0;
            rcnt_q  <= '0;
            dly_q   <= '0;
            en_q    <= '0;
            out_q   <= '0;
            start_q <= '0;
            rst_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            tmo_q   <= tmo_d;
            rcnt_q  <= rcnt_d;
            dly_q   <= dly_d;
            en_q    <= en_d;
            out_q   <= out_d;
            start_q <= start_d;
            rst_q   <= rst_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            terr_q  <= terr_d;
        end
    end

    assign stage_sample       = work_q;
    assign stage_start        = start_q;
    assign stage_reset        = rst_q;
    assign stage_delay_amount = dly_q;
    assign stage_enable       = en_q;
    assign sample_out         = out_q;
    assign sample_valid       = valid_q;
    assign busy               = busy_q;
    assign overrun_err        = ovr_q;
    assign timeout_err        = terr_q;
endmodule

// File: tb/tb_effect_chain_sequencer.sv
// Randomized bench for effect_chain_sequencer: a transaction-level model
// predicts per-cycle outputs; the bench also plays the three effect stages.
module tb_effect_chain_sequencer;
    localparam int TMO = 1023;
    localparam int RC  = 2;
    localparam int NC  = 16384;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b0;
    logic [11:0] sample_in = '0;
    logic [4:0]  delay_amount = '0;
    logic [2:0]  effect_enable = '0;
    logic        clear_flags = 1'b0;
    logic [2:0]  stage_done = '0;
    logic [35:0] stage_out = '0;
    logic [11:0] stage_sample;
    logic [2:0]  stage_start;
    logic        stage_reset;
    logic [4:0]  stage_delay_amount;
    logic [2:0]  stage_enable;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;

    effect_chain_sequencer #(.TIMEOUT(TMO), .RESET_CYCLES(RC)) dut (
        .clock(clk), .reset(reset), .ready(ready), .sample_in(sample_in),
        .delay_amount(delay_amount), .effect_enable(effect_enable),
        .clear_flags(clear_flags), .stage_done(stage_done), .stage_out(stage_out),
        .stage_sample(stage_sample), .stage_start(stage_start), .stage_reset(stage_reset),
        .stage_delay_amount(stage_delay_amount), .stage_enable(stage_enable),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Per-cycle expectations, indexed by cycle number
    bit        exp_busy [NC];
    bit        exp_rst  [NC];
    bit        exp_valid[NC];
    bit [2:0]  exp_start[NC];
    bit [11:0] exp_sout [NC];
    bit        ovr_ev   [NC];
    bit        tmo_ev   [NC];
    bit        clr_ev   [NC];

    int        n_chk = 0, n_err = 0;
    int        cyc = 0, free_at = 0, cfg_upd = -1, ss_at = -1;
    bit [11:0] ss_val;
    bit        ovr_exp = 1'b0, tmo_exp = 1'b0;
    logic [2:0] m_en = '0, cfg_new_en = '0, cur_en = '0;
    logic [4:0] m_dly = '0, cfg_new_dly = '0, cur_dly = '0;
    // Stage behaviour plan: done D cycles after start (0 = never) with value V
    int        plan_d[3] = '{2, 2, 2};
    logic [11:0] plan_v[3] = '{12'h0, 12'h0, 12'h0};
    int        drop_at[3] = '{-1, -1, -1};
    int        raise_at[3] = '{-1, -1, -1};
    logic [11:0] rv[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        ovr_exp = ovr_ev[cyc-1] | (ovr_exp & ~clr_ev[cyc-1]);
        tmo_exp = tmo_ev[cyc-1] | (tmo_exp & ~clr_ev[cyc-1]);
        if (cyc == cfg_upd) begin
            m_en  = cfg_new_en;
            m_dly = cfg_new_dly;
        end
        chk("busy",         32'(busy),               32'(exp_busy[cyc]));
        chk("stage_reset",  32'(stage_reset),        32'(exp_rst[cyc]));
        chk("sample_valid", 32'(sample_valid),       32'(exp_valid[cyc]));
        chk("stage_start",  32'(stage_start),        32'(exp_start[cyc]));
        chk("overrun_err",  32'(overrun_err),        32'(ovr_exp));
        chk("timeout_err",  32'(timeout_err),        32'(tmo_exp));
        chk("stage_enable", 32'(stage_enable),       32'(m_en));
        chk("stage_delay",  32'(stage_delay_amount), 32'(m_dly));
        if (exp_valid[cyc]) begin
            chk("sample_out",       32'(sample_out),   32'(exp_sout[cyc]));
            chk("stage_sample_end", 32'(stage_sample), 32'(exp_sout[cyc]));
        end
        if (cyc == ss_at) chk("stage_sample_cap", 32'(stage_sample), 32'(ss_val));
        for (int k = 0; k < 3; k++) begin
            if (stage_start[k]) begin
                drop_at[k]  = cyc + 2;
                raise_at[k] = (plan_d[k] == 0) ? -1 : cyc + plan_d[k];
                rv[k]       = plan_v[k];
            end
            if (cyc == raise_at[k]) begin
                stage_done[k]         = 1'b1;
                stage_out[12*k +: 12] = rv[k];
            end else if (cyc == drop_at[k]) begin
                stage_done[k] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs, predict its consequences, advance the clock.
    task automatic tick(input bit rdy, input logic [11:0] smp, input logic [4:0] dly,
                        input logic [2:0] en, input bit clr);
        bit        idle;
        int        c;
        bit [11:0] w;
        ready = rdy; sample_in = smp; delay_amount = dly; effect_enable = en; clear_flags = clr;
        clr_ev[cyc] = clr;
        idle = (cyc >= free_at);
        if (idle && ({dly, en} != {m_dly, m_en})) begin
            for (int i = 1; i <= RC; i++) begin
                exp_busy[cyc+i] = 1'b1;
                exp_rst[cyc+i]  = 1'b1;
            end
            cfg_upd = cyc + 1; cfg_new_en = en; cfg_new_dly = dly;
            free_at = cyc + RC + 1;
            if (rdy) ovr_ev[cyc] = 1'b1;
        end else if (rdy && !idle) begin
            ovr_ev[cyc] = 1'b1;
        end else if (rdy) begin
            c = cyc + 1; w = smp;
            ss_at = cyc + 1; ss_val = smp;
            for (int k = 0; k < 3; k++) begin
                if (m_en[k]) begin
                    exp_start[c] = 3'(1 << k);
                    if (plan_d[k] != 0 && plan_d[k] <= TMO + 1) begin
                        w = plan_v[k];
                        c = c + 1 + plan_d[k];
                    end else begin
                        tmo_ev[c + TMO + 1] = 1'b1;
                        c = c + TMO + 2;
                    end
                end else begin
                    c = c + 1;
                end
            end
            for (int i = cyc + 1; i <= c; i++) exp_busy[i] = 1'b1;
            exp_valid[c] = 1'b1;
            exp_sout[c]  = w;
            free_at = c + 1;
        end
        step();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < free_at && n < 5000) begin
            tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
            n++;
        end
        chk("wait_bound", 32'(n >= 5000), 32'd0);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; ready = 1'b0; clear_flags = 1'b0;
        for (int i = cyc; i < NC; i++) begin
            exp_busy[i] = 0; exp_rst[i] = 0; exp_valid[i] = 0; exp_start[i] = 0;
            exp_sout[i] = 0; ovr_ev[i] = 0; tmo_ev[i] = 0; clr_ev[i] = 0;
        end
        ovr_exp = 0; tmo_exp = 0; m_en = '0; m_dly = '0;
        cfg_upd = -1; free_at = 0; ss_at = -1;
        stage_done = '0;
        for (int k = 0; k < 3; k++) begin
            drop_at[k] = -1; raise_at[k] = -1;
        end
        repeat (n) step();
        reset = 1'b0;
    endtask

    initial begin
        bit          rdy, clr;
        logic [11:0] smp;
        logic [2:0]  n_en;
        logic [4:0]  n_dly;
        int          r;

        apply_reset(3);
        chk("reset_sample_out",   32'(sample_out),   32'd0);
        chk("reset_stage_sample", 32'(stage_sample), 32'd0);
        tick(1'b0, 12'h000, 5'd0, 3'b000, 1'b0);

        // All stages bypassed
        tick(1'b1, 12'h123, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("bypass_result", 32'(sample_out), 32'h123);

        // Stage 1 only, done on first WAIT cycle
        cur_en = 3'b010;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        plan_d[1] = 2; plan_v[1] = 12'hF00;
        tick(1'b1, 12'h055, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("stage1_result", 32'(sample_out), 32'hF00);

        // Delay change 3 -> 5
        cur_dly = 5'd3;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        cur_dly = 5'd5;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("delay_latched", 32'(stage_delay_amount), 32'd5);

        // Stage 0 never done -> timeout, sample passes unchanged
        cur_en = 3'b001;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        plan_d[0] = 0;
        tick(1'b1, 12'h7A5, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("timeout_result", 32'(sample_out), 32'h7A5);
        chk("timeout_flag",   32'(timeout_err), 32'd1);
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b1);
        chk("timeout_clear",  32'(timeout_err), 32'd0);

        // Done on the last allowed WAIT cycle, then one cycle too late
        plan_d[0] = TMO + 1; plan_v[0] = 12'h3C3;
        tick(1'b1, 12'h111, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("last_wait_result", 32'(sample_out), 32'h3C3);
        plan_d[0] = TMO + 2; plan_v[0] = 12'h0F0;
        tick(1'b1, 12'h222, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("late_done_result", 32'(sample_out), 32'h222);
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b1);

        // Second sample mid-chain is dropped
        cur_en = 3'b000;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        tick(1'b1, 12'h2AA, cur_dly, cur_en, 1'b0);
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        tick(1'b1, 12'h155, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("overrun_first_sample", 32'(sample_out),  32'h2AA);
        chk("overrun_flag",         32'(overrun_err), 32'd1);
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b1);
        chk("overrun_clear",        32'(overrun_err), 32'd0);

        // Randomized traffic
        for (int t = 0; t < 700 && cyc < NC - 200; t++) begin
            rdy = 1'b0;
            smp = 12'($urandom);
            clr = ($urandom_range(0, 39) == 0);
            if (cyc >= free_at) begin
                r = int'($urandom_range(0, 99));
                if (r < 8) begin
                    n_en  = 3'($urandom);
                    n_dly = 5'($urandom);
                    if ({n_dly, n_en} == {cur_dly, cur_en}) n_en = ~n_en;
                    cur_en = n_en; cur_dly = n_dly;
                    rdy = ($urandom_range(0, 2) == 0);
                end else if (r < 60) begin
                    rdy = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        plan_d[k] = int'($urandom_range(2, 6));
                        plan_v[k] = 12'($urandom);
                    end
                end
            end else begin
                rdy = ($urandom_range(0, 24) == 0);
            end
            tick(rdy, smp, cur_dly, cur_en, clr);
        end
        wait_idle();

        // Reset during WAIT aborts the chain; nonzero config then forces CFG_RESET
        cur_en = 3'b100;
        tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        plan_d[2] = 6; plan_v[2] = 12'h0AB;
        tick(1'b1, 12'h321, cur_dly, cur_en, 1'b0);
        repeat (4) tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        chk("in_wait_busy", 32'(busy), 32'd1);
        apply_reset(1);
        chk("abort_busy",         32'(busy),         32'd0);
        chk("abort_sample_out",   32'(sample_out),   32'd0);
        chk("abort_stage_sample", 32'(stage_sample), 32'd0);
        repeat (12) tick(1'b0, 12'h000, cur_dly, cur_en, 1'b0);
        wait_idle();
        chk("post_reset_cfg", 32'(stage_enable), 32'b100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
